pre_pa_transmit: RTL and testbench
==================================

PRE_PA_TRANSMIT -- requirements
Module: pre_pa_transmit

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 8: Clk cycles between PaEnable rising and the first data bit (legal 1..255).
REQ-002 SHALL have parameter GUARD_CYCLES, default 4: Clk cycles of quiet line after the last bit, before PaEnable falls (legal 1..255).
REQ-003 SHALL have port Clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port TxData, input, 8: byte to transmit, sent MSB first.
REQ-006 SHALL have port TxLast, input, 1: marks the final byte of a burst; qualified by TxValid.
REQ-007 SHALL have port TxValid, input, 1: source holds a byte.
REQ-008 SHALL have port TxReady, output, 1: block accepts the byte; transfer occurs when TxValid and TxReady are both 1.
REQ-009 SHALL have ports OuterTransmitP and OuterTransmitN, output, 1 each: differential bit drive toward the PA.
REQ-010 SHALL have port PaEnable, output, 1: PA bias enable.
REQ-011 SHALL have port TrSwitchTx, output, 1: T/R switch in transmit position.
REQ-012 SHALL have port Underrun, output, 1: sticky flag; source starved mid-burst.

Function
REQ-013 SHALL implement FSM states IDLE, SWITCH, WARMUP, SHIFT, GUARD, RELEASE.
REQ-014 IDLE: TxReady=1, TrSwitchTx=0, PaEnable=0, P=N=0; a transfer loads a one-entry holding register and moves to SWITCH.
REQ-015 SWITCH lasts exactly 1 cycle with TrSwitchTx=1, PaEnable=0, then moves to WARMUP.
REQ-016 WARMUP holds TrSwitchTx=1, PaEnable=1, P=N=0 for exactly WARMUP_CYCLES cycles, then moves to SHIFT.
REQ-017 SHIFT moves the holding register into a shift register and drives one bit per cycle: P=bit, N=~bit.
REQ-018 The first bit of the first byte SHALL appear on the line exactly 1+WARMUP_CYCLES+1 cycles after the accepting edge.
REQ-019 In SHIFT, TxReady SHALL equal 1 while the holding register is empty and no TxLast byte has been accepted in this burst.
REQ-020 On the last bit of a byte, if the holding register is full, the next byte SHALL start on the following cycle with no gap.
REQ-021 A transfer on the same cycle the holding register is drained SHALL be accepted and SHALL count as full.
REQ-022 When a byte accepted with TxLast finishes shifting, the FSM SHALL move to GUARD.
REQ-023 If a byte without TxLast finishes with the holding register empty, Underrun SHALL set to 1, the line SHALL go quiet, and the FSM SHALL move to GUARD; a byte offered in that cycle SHALL NOT be accepted.
REQ-024 GUARD holds P=N=0, PaEnable=1, TrSwitchTx=1, TxReady=0 for GUARD_CYCLES cycles, then moves to RELEASE.
REQ-025 RELEASE lasts 1 cycle with PaEnable=0, TrSwitchTx=1, then moves to IDLE; TrSwitchTx therefore always outlasts PaEnable by 1 cycle on both edges.
REQ-026 TxReady SHALL be 0 in SWITCH, WARMUP, GUARD and RELEASE.
REQ-027 P and N SHALL never both be 1.
REQ-028 Underrun SHALL clear only on Reset.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While Reset=1 at a Clk edge: FSM=IDLE, holding register and counters cleared, TxReady=0, P=N=0, PaEnable=0, TrSwitchTx=0, Underrun=0.
REQ-031 TxReady SHALL return to 1 the cycle after Reset deasserts.
REQ-032 Reset mid-burst SHALL drop PaEnable and TrSwitchTx on the same edge, abandoning remaining data with no guard period.

Configuration
REQ-033 Macro PRE_PA_PARITY_EN defined: each byte SHALL be followed by one odd-parity bit (XOR of the 8 data bits, inverted), giving 9 bit-cycles per byte; the REQ-020 no-gap rule applies after the parity bit.
REQ-034 Macro PRE_PA_PARITY_EN undefined: 8 bit-cycles per byte and no parity logic present.

Verification
REQ-035 Reset, then one byte 0xA5 with TxLast -> TrSwitchTx rises at edge+1, PaEnable at +2; P sequence 1,0,1,0,0,1,0,1 starting cycle 10; 4 guard cycles; PaEnable falls, then TrSwitchTx 1 cycle later.
REQ-036 Back-to-back bytes 0x01, 0xFF(TxLast) with TxValid held high -> 16 contiguous bit cycles, no gap; Underrun=0.
REQ-037 Bytes 0x3C then a 5-cycle source stall -> Underrun=1 after bit 8; GUARD entered; later byte accepted only after IDLE is reached.
REQ-038 Reset asserted during bit 3 of 0xF0 -> next edge all outputs 0; after release, TxReady=1 and a new burst timing matches REQ-035.
REQ-039 PRE_PA_PARITY_EN defined, byte 0x07 TxLast -> 9 bits 0,0,0,0,0,1,1,1,0 (parity 0, three ones).
REQ-040 Bench SHALL check REQ-027 and the PaEnable/TrSwitchTx nesting on every cycle of all scenarios.

Source files
------------

// File: rtl/pre_pa_transmit_if.sv
// Byte stream into pre_pa_transmit. A byte moves on a rising Clk edge where TxValid and TxReady are both 1.
// TxData/TxLast must stay stable while TxValid is high.
interface pre_pa_transmit_if;
  logic [7:0] TxData;
  logic       TxLast;
  logic       TxValid;
  logic       TxReady;

  modport master (output TxData, TxLast, TxValid, input TxReady);
  modport slave  (input TxData, TxLast, TxValid, output TxReady);
endinterface

// File: rtl/pre_pa_transmit.sv
// Sequences the T/R switch and PA enable around a serial byte burst. The burst is sent MSB first, one bit per cycle.
// Defining PRE_PA_PARITY_EN appends an odd-parity bit to every byte.
module pre_pa_transmit #(
  parameter int WARMUP_CYCLES = 8,
  parameter int GUARD_CYCLES  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  pre_pa_transmit_if.slave  tx,
  output logic              OuterTransmitP,
  output logic              OuterTransmitN,
  output logic              PaEnable,
  output logic              TrSwitchTx,
  output logic              Underrun,
  output logic [2:0]        DbgState
);
`ifdef PRE_PA_PARITY_EN
  localparam int BITS = 9;
`else
  localparam int BITS = 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SWITCH, S_WARMUP, S_SHIFT, S_GUARD, S_RELEASE
  } state_t;

  state_t          r_state, w_state_nx;
  logic [7:0]      r_cnt, w_cnt_nx;
  logic [7:0]      r_hold, w_hold_nx;
  logic            r_hold_full, w_hold_full_nx;
  logic            r_hold_last, w_hold_last_nx;
  logic [BITS-1:0] r_shift, w_shift_nx;
  logic            r_shift_last, w_shift_last_nx;
  logic            r_last_seen, w_last_seen_nx;
  logic            w_xfer, w_underrun_evt, w_ready_nx;
  logic            r_ready, r_p, r_n, r_pa, r_tr, r_underrun, r_underrun_evt;

  function automatic logic [BITS-1:0] frame(input logic [7:0] d);
`ifdef PRE_PA_PARITY_EN
    return {d, ~^d};
`else
    return d;
`endif
  endfunction

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_hold_nx       = r_hold;
    w_hold_full_nx  = r_hold_full;
    w_hold_last_nx  = r_hold_last;
    w_shift_nx      = r_shift;
    w_shift_last_nx = r_shift_last;
    w_last_seen_nx  = r_last_seen;
    w_underrun_evt  = 1'b0;
    w_xfer          = tx.TxValid & r_ready;

    if (w_xfer) begin
      w_hold_nx      = tx.TxData;
      w_hold_last_nx = tx.TxLast;
      w_hold_full_nx = 1'b1;
      if (tx.TxLast) w_last_seen_nx = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_last_seen_nx = w_xfer & tx.TxLast;
        if (w_xfer) w_state_nx = S_SWITCH;
      end
      S_SWITCH: begin
        w_cnt_nx   = 8'd0;
        w_state_nx = S_WARMUP;
      end
      S_WARMUP: begin
        if (r_cnt == 8'(WARMUP_CYCLES - 1)) begin
          w_cnt_nx        = 8'd0;
          w_shift_nx      = frame(r_hold);
          w_shift_last_nx = r_hold_last;
          w_hold_full_nx  = 1'b0;
          w_state_nx      = S_SHIFT;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_SHIFT: begin
        w_shift_nx = {r_shift[BITS-2:0], 1'b0};
        if (r_cnt == 8'(BITS - 1)) begin
          w_cnt_nx = 8'd0;
          if (r_shift_last) begin
            w_state_nx = S_GUARD;
          end else if (r_hold_full) begin
            // A byte taken on the draining edge refills the holding register at once.
            w_shift_nx      = frame(r_hold);
            w_shift_last_nx = r_hold_last;
            w_hold_full_nx  = w_xfer;
          end else begin
            w_underrun_evt = 1'b1;
            w_state_nx     = S_GUARD;
          end
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_GUARD: begin
        if (r_cnt == 8'(GUARD_CYCLES - 1)) begin
          w_cnt_nx   = 8'd0;
          w_state_nx = S_RELEASE;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_RELEASE: begin
        w_last_seen_nx = 1'b0;
        w_state_nx     = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Ready stays low on the final bit of a byte. A byte offered then is refused, and the burst counts as starved.
    w_ready_nx = (w_state_nx == S_IDLE) ||
                 ((w_state_nx == S_SHIFT) && !w_hold_full_nx && !w_last_seen_nx &&
                  (w_cnt_nx != 8'(BITS - 1)));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Line outputs register the decode of the current state, so they trail the FSM by one cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hold         <= 8'd0;
      r_hold_full    <= 1'b0;
      r_hold_last    <= 1'b0;
      r_shift        <= '0;
      r_shift_last   <= 1'b0;
      r_last_seen    <= 1'b0;
      r_ready        <= 1'b0;
      r_p            <= 1'b0;
      r_n            <= 1'b0;
      r_pa           <= 1'b0;
      r_tr           <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_evt <= 1'b0;
    end else begin
      r_hold         <= w_hold_nx;
      r_hold_full    <= w_hold_full_nx;
      r_hold_last    <= w_hold_last_nx;
      r_shift        <= w_shift_nx;
      r_shift_last   <= w_shift_last_nx;
      r_last_seen    <= w_last_seen_nx;
      r_ready        <= w_ready_nx;
      r_p            <= (r_state == S_SHIFT) &  r_shift[BITS-1];
      r_n            <= (r_state == S_SHIFT) & ~r_shift[BITS-1];
      r_pa           <= (r_state == S_WARMUP) || (r_state == S_SHIFT) || (r_state == S_GUARD);
      r_tr           <= (r_state != S_IDLE);
      r_underrun_evt <= w_underrun_evt;
      r_underrun     <= r_underrun | r_underrun_evt;
    end
  end

  assign tx.TxReady     = r_ready;
  assign OuterTransmitP = r_p;
  assign OuterTransmitN = r_n;
  assign PaEnable       = r_pa;
  assign TrSwitchTx     = r_tr;
  assign Underrun       = r_underrun;
  assign DbgState       = r_state;
endmodule

// File: tb/tb_pre_pa_transmit.sv
// Directed bench for pre_pa_transmit. A burst-level line model is checked on every cycle, alongside hand-computed literals.
// Build with PRE_PA_PARITY_EN to add the parity scenario.
`timescale 1ns/1ps
module tb_pre_pa_transmit;
  localparam int W = 8;
  localparam int G = 4;
`ifdef PRE_PA_PARITY_EN
  localparam int NB = 9;
  localparam logic [8:0] LIT_A5 = 9'b101001011;
`else
  localparam int NB = 8;
  localparam logic [8:0] LIT_A5 = 9'h0A5;
`endif

  // clock / reset
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic P, N, PaEnable, TrSwitchTx, Underrun;
  logic [2:0] dbg_state;
  pre_pa_transmit_if bus();

  pre_pa_transmit #(.WARMUP_CYCLES(W), .GUARD_CYCLES(G)) dut (
    .Clk(Clk), .Reset(Reset), .tx(bus),
    .OuterTransmitP(P), .OuterTransmitN(N), .PaEnable(PaEnable),
    .TrSwitchTx(TrSwitchTx), .Underrun(Underrun), .DbgState(dbg_state)
  );

  // scoreboard: one entry per line cycle, packed as {P, N, PaEnable, TrSwitchTx, underrun_event}
  logic [4:0] exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0, bit_cycles = 0;
  logic u_sticky = 1'b0, in_burst = 1'b0, prev_pa = 1'b0, prev_tr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push_n(input logic [4:0] e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endfunction

  function automatic void model_close(input logic starved);
    push_n({4'b0011, starved}, G);
    push_n({4'b0001, starved}, 1);
    in_burst = 1'b0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic last);
    if (!in_burst) begin
      push_n(5'b00000, 1);
      push_n(5'b00010, 1);
      push_n(5'b00110, W);
      in_burst = 1'b1;
    end
    for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], ~d[i], 3'b110});
`ifdef PRE_PA_PARITY_EN
    exp_q.push_back({~^d, ^d, 3'b110});
`endif
    if (last) model_close(1'b0);
  endfunction

  // compare: advance to the falling edge and check every output against the model
  task automatic tick();
    logic [4:0] e;
    @(negedge Clk);
    cyc++;
    e = 5'b0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    u_sticky = u_sticky | e[0];
    chk("line_p", P, e[4]);
    chk("line_n", N, e[3]);
    chk("pa_enable", PaEnable, e[2]);
    chk("tr_switch", TrSwitchTx, e[1]);
    chk("underrun", Underrun, u_sticky);
    chk("p_n_exclusive", P & N, 0);
    chk("pa_inside_tr", PaEnable & ~TrSwitchTx, 0);
    if (PaEnable && !prev_pa) chk("tr_leads_pa", prev_tr, 1);
    if (!PaEnable && prev_pa && !Reset) chk("tr_trails_pa", TrSwitchTx, 1);
    if (P | N) bit_cycles++;
    prev_pa = PaEnable;
    prev_tr = TrSwitchTx;
  endtask

  // driver: offer a byte until accepted; returns at the falling edge after the accepting edge
  task automatic send_byte(input logic [7:0] d, input logic last, input logic expect_idle);
    int waited = 0;
    bus.TxData  = d;
    bus.TxLast  = last;
    bus.TxValid = 1'b1;
    while (!bus.TxReady && waited < 60) begin
      tick();
      waited++;
    end
    if (!bus.TxReady) begin
      chk("accept_timeout", waited, 0);
    end else begin
      if (expect_idle) chk("accept_only_in_idle", exp_q.size(), 0);
      model_accept(d, last);
      tick();
    end
    bus.TxValid = 1'b0;
  endtask

  task automatic run_single(input logic [7:0] d, input logic [8:0] lit);
    send_byte(d, 1'b1, 1'b1);
    for (int k = 1; k <= W + NB + G + 5; k++) begin
      tick();
      if (k == 1) begin
        chk("switch_tr_rise", TrSwitchTx, 1);
        chk("switch_pa_low", PaEnable, 0);
      end
      if (k == 2) chk("warmup_pa_rise", PaEnable, 1);
      if (k == 5) chk("warmup_ready_low", bus.TxReady, 0);
      if (k >= W + 2 && k < W + 2 + NB) chk("bit_literal", P, lit[NB - 1 - (k - W - 2)]);
      if (k >= W + 2 + NB && k < W + 2 + NB + G) begin
        chk("guard_quiet", P | N, 0);
        chk("guard_pa_high", PaEnable, 1);
        chk("guard_ready_low", bus.TxReady, 0);
      end
      if (k == W + 2 + NB + G) begin
        chk("release_pa_low", PaEnable, 0);
        chk("release_tr_high", TrSwitchTx, 1);
      end
      if (k == W + 3 + NB + G) chk("idle_tr_low", TrSwitchTx, 0);
    end
  endtask

  initial begin
    bus.TxData  = 8'h00;
    bus.TxLast  = 1'b0;
    bus.TxValid = 1'b0;

    repeat (3) tick();
    chk("reset_ready", bus.TxReady, 0);
    chk("reset_pa", PaEnable, 0);
    chk("reset_tr", TrSwitchTx, 0);
    Reset = 1'b0;
    tick();
    chk("ready_after_reset", bus.TxReady, 1);

    // single byte 0xA5 with full timing literals
    run_single(8'hA5, LIT_A5);
    repeat (3) tick();

    // back-to-back 0x01, 0xFF with TxValid held
    bit_cycles = 0;
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b0);
    repeat (30) tick();
    chk("b2b_bit_cycles", bit_cycles, 2 * NB);
    chk("b2b_underrun", Underrun, 0);
    chk("b2b_drained", exp_q.size(), 0);

    // 0x3C followed by a silent source; next byte offered on the final bit
    send_byte(8'h3C, 1'b0, 1'b1);
    model_close(1'b1);
    repeat (W + NB) tick();
    chk("starve_underrun_pre", Underrun, 0);
    send_byte(8'h81, 1'b1, 1'b1);
    repeat (W + NB + G + 6) tick();
    chk("underrun_sticky", Underrun, 1);

    // reset during bit 3 of 0xF0
    send_byte(8'hF0, 1'b1, 1'b1);
    repeat (W + 4) tick();
    chk("bit3_of_f0", P, 1);
    chk("underrun_before_reset", Underrun, 1);
    Reset = 1'b1;
    exp_q.delete();
    u_sticky = 1'b0;
    in_burst = 1'b0;
    tick();
    chk("midreset_p", P, 0);
    chk("midreset_n", N, 0);
    chk("midreset_pa", PaEnable, 0);
    chk("midreset_tr", TrSwitchTx, 0);
    chk("midreset_underrun", Underrun, 0);
    chk("midreset_ready", bus.TxReady, 0);
    tick();
    Reset = 1'b0;
    tick();
    chk("ready_after_midreset", bus.TxReady, 1);
    run_single(8'hA5, LIT_A5);

`ifdef PRE_PA_PARITY_EN
    repeat (3) tick();
    run_single(8'h07, 9'b000001110);
`endif

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
